truth_table_sweeper: RTL and testbench

Sequencer that drives a small combinational DUT through every input combination, captures its output per pattern, and checks the captured truth table against an expected one. It replaces hand-written per-pattern delays in lab benches with a clocked, self-checking controller. It sits between a lab combinational circuit (stimulus out, response in) and the board/bench status logic.

---
 rtl/truth_table_sweeper_pkg.sv | 14 +
 rtl/truth_table_sweeper_settle_timer.sv | 30 +++
 rtl/truth_table_sweeper.sv | 104 ++++++++++
 tb/tb_truth_table_sweeper.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding and defaults.
package sweep_pkg;

  localparam int DEF_N_IN   = 3;
  localparam int DEF_SETTLE = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable down-counter that measures how long a pattern is held before sampling.
// Load sets the count to SETTLE-1; zero flags that the hold time has elapsed.
module settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_zero
);

  localparam int CW = $clog2(SETTLE) + 1;

  logic [CW-1:0] r_cnt;

  // Count down while enabled; a load always wins so a new pattern restarts the hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(SETTLE - 1);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps a small combinational circuit through every input pattern, captures the
// response per pattern and compares the captured truth table to a latched expected one.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [2**N_IN-1:0]   i_expected,
  input  logic                 i_y_in,
  output logic [N_IN-1:0]      o_stim,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [2**N_IN-1:0]   o_table_out,
  output logic [2**N_IN-1:0]   o_mismatch
);

  localparam int NP = 2**N_IN;

  state_t          r_state;
  logic [N_IN:0]   r_idx;
  logic [NP-1:0]   r_table;
  logic [NP-1:0]   r_exp;
  logic            r_busy;
  logic            r_done;

  logic            w_accept;
  logic            w_last;
  logic            w_load;
  logic            w_en;
  logic            w_zero;

  // A start is only honoured when no sweep is running.
  assign w_accept = i_start && ((r_state == IDLE) || (r_state == DONE));
  // Termination is an explicit compare on the last pattern; the counter never wraps.
  assign w_last   = (r_idx == (N_IN+1)'(NP - 1));
  assign w_load   = w_accept || ((r_state == SAMPLE) && !w_last);
  assign w_en     = (r_state == APPLY);

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_load),
    .i_en   (w_en),
    .o_zero (w_zero)
  );

  // Sweep sequencer: steps the pattern, holds it SETTLE cycles, then captures y_in.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_table <= '0;
      r_exp   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_exp   <= i_expected;
            r_idx   <= '0;
            r_table <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= APPLY;
          end
        end
        APPLY: begin
          if (w_zero) r_state <= SAMPLE;
        end
        SAMPLE: begin
          r_table[r_idx[N_IN-1:0]] <= i_y_in;
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx   <= r_idx + (N_IN+1)'(1);
            r_state <= APPLY;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // The pattern counter doubles as the stimulus, so DONE keeps driving the last pattern.
  assign o_stim      = r_idx[N_IN-1:0];
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_table_out = r_table;
  assign o_pass      = r_done && (r_table == r_exp);
  assign o_mismatch  = r_done ? (r_table ^ r_exp) : '0;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper with a behavioural 3-input lab circuit.
module tb_truth_table_sweeper;

  localparam int N_IN   = 3;
  localparam int SETTLE = 2;
  localparam int NP     = 8;
  localparam int PER    = SETTLE + 1;
  localparam int SWEEP  = NP * PER;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NP-1:0] expected;
  logic          y_in;
  logic [N_IN-1:0] stim;
  logic          busy, done, pass;
  logic [NP-1:0] table_out, mismatch;

  // Truth table of the circuit under sweep; bit i is its output for input pattern i.
  logic [NP-1:0] fn;
  assign y_in = fn[stim];

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_expected  (expected),
    .i_y_in      (y_in),
    .o_stim      (stim),
    .o_busy      (busy),
    .o_done      (done),
    .o_pass      (pass),
    .o_table_out (table_out),
    .o_mismatch  (mismatch)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [NP-1:0] fn;
    logic [NP-1:0] exp;
    logic [NP-1:0] tbl;
    logic          pass;
    logic [NP-1:0] mis;
  } vec_t;

  vec_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic check_done();
    vec_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({e.name, " table"},    table_out, e.tbl);
    chk({e.name, " pass"},     pass,      e.pass);
    chk({e.name, " mismatch"}, mismatch,  e.mis);
    chk({e.name, " stim7"},    stim,      3'd7);
    chk({e.name, " busy0"},    busy,      1'b0);
  endtask

  // mode 0: plain sweep, 1: start pulse + expected change mid-sweep, 2: rst at edge 10.
  // Called and returns at a negedge.
  task automatic sweep(input vec_t v, input int mode);
    int edges;
    fn       = v.fn;
    expected = v.exp;
    start    = 1'b1;
    if (mode != 2) sb.push_back(v);
    @(posedge clk);  // E0
    edges = -1;
    for (int j = 0; j <= SWEEP + 10; j++) begin
      @(negedge clk);
      if (j == 0) start = 1'b0;
      if (mode == 1 && j == 4) begin start = 1'b1; expected = ~v.exp; end
      if (mode == 1 && j == 5) start = 1'b0;
      if (mode == 2 && j == 10) begin
        chk("rst stim",     stim,      '0);
        chk("rst busy",     busy,      1'b0);
        chk("rst done",     done,      1'b0);
        chk("rst pass",     pass,      1'b0);
        chk("rst table",    table_out, '0);
        chk("rst mismatch", mismatch,  '0);
        rst   = 1'b0;
        edges = j;
        break;
      end
      if (mode == 2 && j == 9) rst = 1'b1;
      if (done) begin edges = j; break; end
      chk({v.name, " stim_order"}, stim, j / PER);
      chk({v.name, " busy"},       busy, 1'b1);
      @(posedge clk);
    end
    if (edges < 0) begin
      chk({v.name, " done_timeout"}, 32'd0, 32'd1);
    end else if (mode != 2) begin
      chk({v.name, " latency"}, edges, SWEEP);
      check_done();
    end
  endtask

  vec_t vecs[5];
  vec_t maj;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"maj_pass", 8'hE8, 8'hE8, 8'hE8, 1'b1, 8'h00};
    vecs[1] = '{"maj_fail", 8'hE8, 8'hE9, 8'hE8, 1'b0, 8'h01};
    vecs[2] = '{"xor3",     8'h96, 8'h96, 8'h96, 1'b1, 8'h00};
    vecs[3] = '{"and3",     8'h80, 8'h00, 8'h80, 1'b0, 8'h80};
    vecs[4] = '{"zero",     8'h00, 8'hFF, 8'h00, 1'b0, 8'hFF};
    maj     = vecs[0];

    rst = 1'b1; start = 1'b0; fn = '0; expected = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset stim",     stim,      '0);
    chk("reset busy",     busy,      1'b0);
    chk("reset done",     done,      1'b0);
    chk("reset pass",     pass,      1'b0);
    chk("reset table",    table_out, '0);
    chk("reset mismatch", mismatch,  '0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) sweep(vecs[i], 0);

    // Disturbed sweep: stray start and new expected must not matter.
    sweep('{"disturb", 8'hE8, 8'hE8, 8'hE8, 1'b1, 8'h00}, 1);
    expected = 8'hE8;

    // Abort by reset, then a full sweep from IDLE.
    sweep(maj, 2);
    @(negedge clk);
    chk("idle_after_rst busy", busy, 1'b0);
    sweep('{"after_rst", 8'hE8, 8'hE8, 8'hE8, 1'b1, 8'h00}, 0);

    // start held high: back-to-back sweeps with a single DONE cycle between them.
    fn = 8'hE8; expected = 8'hE8; start = 1'b1;
    sb.push_back('{"held1", 8'hE8, 8'hE8, 8'hE8, 1'b1, 8'h00});
    @(posedge clk);
    for (int j = 0; j <= 60; j++) begin
      @(negedge clk);
      if (j == 23 || j == 48) chk("held done_early", done, 1'b0);
      if (j == 24) begin
        chk("held done1", done, 1'b1);
        check_done();
        sb.push_back('{"held2", 8'hE8, 8'hE8, 8'hE8, 1'b1, 8'h00});
      end
      if (j == 25) begin
        chk("held done_drop", done,      1'b0);
        chk("held busy_back", busy,      1'b1);
        chk("held cleared",   table_out, '0);
        chk("held stim0",     stim,      '0);
      end
      if (j == 49) begin
        chk("held done2", done, 1'b1);
        check_done();
        start = 1'b0;
      end
      if (j == 50) begin
        chk("held done_stays", done, 1'b1);
        break;
      end
      if (j == 60) chk("held timeout", 32'd0, 32'd1);
      @(posedge clk);
    end

    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
